// File: rtl/d3s_tune_scheduler_if.sv
// rtl/d3s_tune_scheduler_if.sv - command push bus into the D3S tune scheduler
interface d3s_tune_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [39:0] cmd_tai;
  logic [27:0] cmd_cycles;
  logic [31:0] cmd_tune;
  logic        cmd_load_acc;

  modport master (
    output cmd_valid, cmd_tai, cmd_cycles, cmd_tune, cmd_load_acc,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_tai, cmd_cycles, cmd_tune, cmd_load_acc,
    output cmd_ready
  );
endinterface

// File: rtl/d3s_tune_scheduler.sv
// rtl/d3s_tune_scheduler.sv - timed tune command queue for the D3S DDS datapath
// Commands wait in a FIFO and are applied when WR time reaches their {tai, cycles} target.
module d3s_tune_scheduler #(
  parameter int g_fifo_depth     = 8,
  parameter int g_cycles_per_sec = 125000000,
  parameter int g_late_cnt_width = 16
) (
  input  logic                              clk_ref_i,
  input  logic                              rst_i,
  input  logic                              tm_time_valid_i,
  input  logic [39:0]                       tm_tai_i,
  input  logic [27:0]                       tm_cycles_i,
  input  logic                              enable_i,
  input  logic                              flush_i,
  d3s_tune_scheduler_if.slave               cmd,
  output logic [31:0]                       tune_o,
  output logic                              tune_valid_o,
  output logic                              acc_load_o,
  output logic [$clog2(g_fifo_depth):0]     count_o,
  output logic                              busy_o,
  output logic                              late_o,
  output logic                              bad_cmd_o,
  output logic [g_late_cnt_width-1:0]       late_count_o
);

  localparam int          AW       = $clog2(g_fifo_depth);
  localparam logic [AW:0] DEPTH    = (AW+1)'(g_fifo_depth);
  localparam logic [27:0] CPS      = 28'(g_cycles_per_sec);
  localparam logic [27:0] CPS_LAST = 28'(g_cycles_per_sec - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_FIRE, S_DROP} state_t;
  state_t state_q, state_d;

  logic [39:0] mem_tai    [g_fifo_depth];
  logic [27:0] mem_cycles [g_fifo_depth];
  logic [31:0] mem_tune   [g_fifo_depth];
  logic        mem_load   [g_fifo_depth];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          full, push, cycles_ok, store, pop;
  logic [39:0]   t1_tai;
  logic [27:0]   t1_cycles;
  logic [67:0]   t1_q;
  logic [67:0]   now;
  logic [31:0]   head_tune_q;
  logic          head_load_q;

  assign full          = (count_q == DEPTH);
  assign cmd.cmd_ready = !full && !flush_i;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign cycles_ok     = (cmd.cmd_cycles < CPS);
  assign store         = push && cycles_ok;
  assign pop           = (state_q == S_FIRE) || (state_q == S_DROP);
  assign now           = {tm_tai_i, tm_cycles_i};
  assign count_o       = count_q;
  assign busy_o        = (count_q != '0);

  always_ff @(posedge clk_ref_i) begin
    if (store) begin
      mem_tai[wr_ptr]    <= cmd.cmd_tai;
      mem_cycles[wr_ptr] <= cmd.cmd_cycles;
      mem_tune[wr_ptr]   <= cmd.cmd_tune;
      mem_load[wr_ptr]   <= cmd.cmd_load_acc;
    end
  end

  always_ff @(posedge clk_ref_i) begin
    if (rst_i || flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({store, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head target plus one cycle, carrying into TAI at the end of the second.
  always_comb begin
    t1_tai    = mem_tai[rd_ptr];
    t1_cycles = mem_cycles[rd_ptr] + 28'd1;
    if (mem_cycles[rd_ptr] == CPS_LAST) begin
      t1_tai    = mem_tai[rd_ptr] + 40'd1;
      t1_cycles = '0;
    end
  end

  // CHECK sees T+1 one cycle before FIRE, so the strobe lands on target+2.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (busy_o && enable_i && tm_time_valid_i) state_d = S_LOAD;
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: begin
        if (tm_time_valid_i && enable_i) begin
          if (t1_q == now)      state_d = S_FIRE;
          else if (t1_q < now)  state_d = S_DROP;
        end
      end
      S_FIRE:  state_d = S_IDLE;
      S_DROP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_ref_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      t1_q         <= '0;
      head_tune_q  <= '0;
      head_load_q  <= 1'b0;
      tune_o       <= '0;
      tune_valid_o <= 1'b0;
      acc_load_o   <= 1'b0;
      late_o       <= 1'b0;
      bad_cmd_o    <= 1'b0;
      late_count_o <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_LOAD) begin
        t1_q        <= {t1_tai, t1_cycles};
        head_tune_q <= mem_tune[rd_ptr];
        head_load_q <= mem_load[rd_ptr];
      end
      tune_valid_o <= (state_d == S_FIRE);
      acc_load_o   <= (state_d == S_FIRE) && head_load_q;
      if (state_d == S_FIRE) tune_o <= head_tune_q;
      late_o    <= (state_d == S_DROP);
      bad_cmd_o <= push && !cycles_ok;
      if ((state_d == S_DROP) && (late_count_o != '1))
        late_count_o <= late_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_d3s_tune_scheduler.sv
// tb/tb_d3s_tune_scheduler.sv - directed self-checking bench for d3s_tune_scheduler
module tb_d3s_tune_scheduler;
  localparam logic [27:0] CPS_LAST = 28'd1249;

  logic        clk_ref_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        tm_time_valid_i = 1'b1;
  logic [39:0] tm_tai = 40'd100;
  logic [27:0] tm_cyc = 28'd0;
  logic        enable_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] tune_o;
  logic        tune_valid_o, acc_load_o, busy_o, late_o, bad_cmd_o;
  logic [3:0]  count_o;
  logic [15:0] late_count_o;

  d3s_tune_scheduler_if cmd_if ();

  d3s_tune_scheduler #(
    .g_fifo_depth(8), .g_cycles_per_sec(1250), .g_late_cnt_width(16)
  ) dut (
    .clk_ref_i(clk_ref_i), .rst_i(rst_i), .tm_time_valid_i(tm_time_valid_i),
    .tm_tai_i(tm_tai), .tm_cycles_i(tm_cyc), .enable_i(enable_i), .flush_i(flush_i),
    .cmd(cmd_if), .tune_o(tune_o), .tune_valid_o(tune_valid_o), .acc_load_o(acc_load_o),
    .count_o(count_o), .busy_o(busy_o), .late_o(late_o), .bad_cmd_o(bad_cmd_o),
    .late_count_o(late_count_o)
  );

  always #5 clk_ref_i = ~clk_ref_i;

  int total = 0;
  int bad = 0;
  int fire_n = 0;
  int late_n = 0;
  logic [67:0] fire_time [64];
  logic [31:0] fire_tune [64];
  logic        fire_load [64];
  logic [67:0] tgt [8];
  logic [67:0] t0;
  int          fire_base, late_base;
  logic [15:0] exp_late;

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [67:0] t_add(input logic [67:0] t, input int n);
    logic [39:0] a;
    logic [27:0] c;
    a = t[67:28];
    c = t[27:0];
    for (int i = 0; i < n; i++) begin
      if (c == CPS_LAST) begin
        c = '0;
        a = a + 40'd1;
      end else begin
        c = c + 28'd1;
      end
    end
    return {a, c};
  endfunction

  // One clock: advance WR time, then record this cycle's strobes against it.
  task automatic step();
    @(posedge clk_ref_i);
    #1;
    {tm_tai, tm_cyc} = t_add({tm_tai, tm_cyc}, 1);
    if (tune_valid_o && fire_n < 64) begin
      fire_time[fire_n] = {tm_tai, tm_cyc};
      fire_tune[fire_n] = tune_o;
      fire_load[fire_n] = acc_load_o;
      fire_n++;
    end
    if (late_o) late_n++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [67:0] t, input logic [31:0] tune, input logic load);
    cmd_if.cmd_valid    = 1'b1;
    cmd_if.cmd_tai      = t[67:28];
    cmd_if.cmd_cycles   = t[27:0];
    cmd_if.cmd_tune     = tune;
    cmd_if.cmd_load_acc = load;
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_fires(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (fire_n < n && k < budget) begin
      step();
      k++;
    end
    check(tag, 68'(fire_n), 68'(n));
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_tai = '0;
    cmd_if.cmd_cycles = '0;
    cmd_if.cmd_tune = '0;
    cmd_if.cmd_load_acc = 1'b0;
    steps(3);
    rst_i = 1'b0;
    {tm_tai, tm_cyc} = {40'd100, 28'd0};

    check("rst_tune", 68'(tune_o), 68'd0);
    check("rst_strobes", 68'({tune_valid_o, acc_load_o, late_o, bad_cmd_o, busy_o}), 68'd0);
    check("rst_count", 68'(count_o), 68'd0);
    check("rst_ready", 68'(cmd_if.cmd_ready), 68'd1);
    check("rst_late_count", 68'(late_count_o), 68'd0);

    // Single future command with accumulator load.
    push({40'd101, 28'd500}, 32'h12345, 1'b1);
    check("t1_count", 68'(count_o), 68'd1);
    wait_fires("t1_fired", 1, 2000);
    check("t1_time", fire_time[0], {40'd101, 28'd502});
    check("t1_tune", 68'(fire_tune[0]), 68'h12345);
    check("t1_acc", 68'(fire_load[0]), 68'd1);
    steps(5);
    check("t1_once", 68'(fire_n), 68'd1);
    check("t1_late_count", 68'(late_count_o), 68'd0);
    check("t1_busy", 68'(busy_o), 68'd0);

    // Command already in the past.
    {tm_tai, tm_cyc} = {40'd100, 28'd800};
    push({40'd100, 28'd10}, 32'hAAAA, 1'b0);
    steps(10);
    check("t2_late_pulses", 68'(late_n), 68'd1);
    check("t2_late_count", 68'(late_count_o), 68'd1);
    check("t2_tune_held", 68'(tune_o), 68'h12345);
    check("t2_busy", 68'(busy_o), 68'd0);
    check("t2_no_fire", 68'(fire_n), 68'd1);
    exp_late = 16'd1;

    // Fill to full, including targets across the second boundary.
    {tm_tai, tm_cyc} = {40'd101, 28'd1000};
    for (int i = 0; i < 6; i++) tgt[i] = {40'd101, 28'(1190 + 10 * i)};
    tgt[6] = {40'd101, 28'd1248};
    tgt[7] = {40'd102, 28'd2};
    fire_base = fire_n;
    for (int i = 0; i < 8; i++) push(tgt[i], 32'h100 + 32'(i), 1'(i % 2));
    check("t3_count_full", 68'(count_o), 68'd8);
    check("t3_ready_full", 68'(cmd_if.cmd_ready), 68'd0);
    push({40'd102, 28'd900}, 32'hDEAD, 1'b0);
    check("t3_push_blocked", 68'(count_o), 68'd8);
    wait_fires("t3_all_fired", fire_base + 8, 1500);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_time%0d", i), fire_time[fire_base + i], t_add(tgt[i], 2));
      check($sformatf("t3_tune%0d", i), 68'(fire_tune[fire_base + i]), 68'h100 + 68'(i));
      check($sformatf("t3_acc%0d", i), 68'(fire_load[fire_base + i]), 68'(i % 2));
    end
    step();
    check("t3_count_empty", 68'(count_o), 68'd0);

    // Target on the last cycle of a second: T+1 carries into TAI.
    fire_base = fire_n;
    push({40'd102, 28'd1249}, 32'h5A5A, 1'b0);
    wait_fires("t3w_fired", fire_base + 1, 1400);
    check("t3w_time", fire_time[fire_base], {40'd103, 28'd1});

    // Second command only 3 cycles after the first is late.
    fire_base = fire_n;
    late_base = late_n;
    t0 = t_add({tm_tai, tm_cyc}, 50);
    push(t0, 32'h777, 1'b0);
    push(t_add(t0, 3), 32'h888, 1'b0);
    steps(70);
    check("t3s_fired", 68'(fire_n - fire_base), 68'd1);
    check("t3s_first_time", fire_time[fire_base], t_add(t0, 2));
    check("t3s_late", 68'(late_n - late_base), 68'd1);
    exp_late = exp_late + 16'd1;
    check("t3s_late_count", 68'(late_count_o), 68'(exp_late));

    // Bad cycles field.
    push({40'd104, 28'd1250}, 32'hBAD, 1'b0);
    check("t4_bad_strobe", 68'(bad_cmd_o), 68'd1);
    check("t4_count", 68'(count_o), 68'd0);
    step();
    check("t4_bad_single", 68'(bad_cmd_o), 68'd0);

    // Flush three pending commands.
    fire_base = fire_n;
    t0 = {tm_tai, tm_cyc};
    for (int i = 0; i < 3; i++) push(t_add(t0, 300 + 10 * i), 32'h900 + 32'(i), 1'b0);
    steps(3);
    flush_i = 1'b1;
    #1;
    check("t5_ready_flush", 68'(cmd_if.cmd_ready), 68'd0);
    step();
    flush_i = 1'b0;
    check("t5_count", 68'(count_o), 68'd0);
    check("t5_busy", 68'(busy_o), 68'd0);
    steps(400);
    check("t5_no_fire", 68'(fire_n - fire_base), 68'd0);
    check("t5_late_count", 68'(late_count_o), 68'(exp_late));

    // Time invalid across the target, then late on return.
    fire_base = fire_n;
    late_base = late_n;
    push(t_add({tm_tai, tm_cyc}, 100), 32'hABC, 1'b0);
    steps(5);
    tm_time_valid_i = 1'b0;
    steps(2000);
    check("t6_no_fire_invalid", 68'(fire_n - fire_base), 68'd0);
    check("t6_no_late_invalid", 68'(late_n - late_base), 68'd0);
    tm_time_valid_i = 1'b1;
    steps(10);
    check("t6_late_on_return", 68'(late_n - late_base), 68'd1);
    exp_late = exp_late + 16'd1;
    check("t6_late_count", 68'(late_count_o), 68'(exp_late));
    check("t6_no_fire", 68'(fire_n - fire_base), 68'd0);

    // Reset while a command waits.
    push(t_add({tm_tai, tm_cyc}, 200), 32'hCCC, 1'b1);
    steps(5);
    rst_i = 1'b1;
    steps(2);
    check("t7_tune", 68'(tune_o), 68'd0);
    check("t7_late_count", 68'(late_count_o), 68'd0);
    check("t7_count", 68'(count_o), 68'd0);
    check("t7_ready", 68'(cmd_if.cmd_ready), 68'd1);
    check("t7_strobes", 68'({tune_valid_o, acc_load_o, late_o, bad_cmd_o, busy_o}), 68'd0);
    rst_i = 1'b0;
    fire_base = fire_n;
    steps(300);
    check("t7_quiet", 68'(fire_n - fire_base), 68'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
